adder_sweep_checker: RTL and testbench
======================================

ADDER_SWEEP_CHECKER -- requirements
Module: adder_sweep_checker

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, legal range 1..255: clocks the DUT outputs are allowed to settle per vector.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-003 start  input  1  one-cycle request to begin a full sweep.
REQ-004 A  output  4  operand A driven to the 4-bit adder under test.
REQ-005 B  output  4  operand B driven to the adder.
REQ-006 Cin  output  1  carry-in driven to the adder.
REQ-007 S  input  4  sum returned by the adder.
REQ-008 Cout  input  1  carry-out returned by the adder.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high from sweep completion until the next accepted start.
REQ-011 pass  output  1  high when done=1 and err_count=0.
REQ-012 err_count  output  10  number of mismatching vectors in the current or last sweep.
REQ-013 fail_vec  output  9  first failing {A,B,Cin}; present only per REQ-027.
REQ-014 fail_obs  output  5  {Cout,S} observed at the first failure; present only per REQ-027.

Function
REQ-015 The block SHALL implement states IDLE, SETTLE, CHECK and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL, at that edge, load A=0, B=0, Cin=0, clear err_count, load the settle counter to SETTLE_CYCLES-1 and enter SETTLE.
REQ-017 Vector order SHALL be A outer (0..15), B middle (0..15), Cin inner (0 then 1): 512 vectors, index {A,B,Cin} incrementing by 1.
REQ-018 SETTLE SHALL decrement the counter each clock and enter CHECK on the clock after the counter reaches 0.
REQ-019 CHECK SHALL last one clock, sample S and Cout at its ending edge and compare {Cout,S} with the 5-bit value A+B+Cin.
REQ-020 A mismatch SHALL increment err_count; its maximum value is 512, so it never saturates.
REQ-021 In CHECK, if the index is not 511, the block SHALL advance the index, reload the counter and return to SETTLE; if it is 511, it SHALL enter DONE with A, B and Cin holding 15, 15 and 1.
REQ-022 Each vector SHALL take SETTLE_CYCLES+1 clocks; done SHALL rise exactly 512*(SETTLE_CYCLES+1) clocks after the edge that accepted start.
REQ-023 busy SHALL be 1 in SETTLE and CHECK; done SHALL be 1 only in DONE; start while busy SHALL be ignored.
REQ-024 A, B and Cin SHALL change only on the edge that leaves CHECK or accepts start, and SHALL be registered outputs.

Reset
REQ-025 With rst_n=0, the block SHALL immediately, without a clock, set state IDLE, A=0, B=0, Cin=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_obs=0 and the counter to 0; this applies at any point, including mid-sweep.
REQ-026 After rst_n deasserts, the block SHALL remain in IDLE until start is sampled high.

Configuration
REQ-027 When ADDER_SWEEP_FAILCAP_EN is defined, the block SHALL capture fail_vec and fail_obs on the first mismatch of a sweep, hold them until the next accepted start, and clear them on that start.
REQ-028 When ADDER_SWEEP_FAILCAP_EN is undefined, fail_vec and fail_obs SHALL still exist as ports and SHALL be tied to 0, and no capture registers SHALL be built.

Verification
REQ-029 Correct adder model, SETTLE_CYCLES=4, start pulsed -> done rises 2560 clocks later; err_count=0, pass=1, busy=0.
REQ-030 Adder with Cout stuck at 0, FAILCAP enabled -> err_count=256, pass=0, fail_vec={A=0,B=15,Cin=1}, fail_obs=5'b00000.
REQ-031 Adder with S[0] stuck at 0 -> err_count=256, pass=0; rerun after start with a correct model -> err_count=0, pass=1.
REQ-032 rst_n pulled low 1000 clocks into a sweep -> all outputs are 0 with no clock edge; a new start completes a clean 2560-clock sweep.
REQ-033 start pulsed again while busy, and SETTLE_CYCLES=1 -> the second start is ignored; done rises exactly 1024 clocks after the first start.
REQ-034 FAILCAP undefined with a faulty adder -> fail_vec=0 and fail_obs=0 throughout; err_count is unchanged from the enabled build.

Source files
------------

// File: rtl/adder_sweep_checker.sv
// ---------------------------------------------------------------------------
// adder_sweep_checker
//
// Exhaustively exercises an external 4-bit adder. For every {A,B,Cin} vector
// (A outer, B middle, Cin inner, 512 vectors) the operands are held for
// SETTLE_CYCLES clocks so the adder outputs can settle. The returned
// {Cout,S} is then compared against A+B+Cin in a single CHECK clock.
// Mismatching vectors are counted in err_count.
//
// Optional feature (macro ADDER_SWEEP_FAILCAP_EN):
//   defined   -> the first failing vector and the value observed for it are
//                captured on fail_vec / fail_obs and held until the next start.
//   undefined -> fail_vec / fail_obs are tied to zero and no capture
//                registers are built.
//
// Parameters:
//   SETTLE_CYCLES  1..255  clocks the adder outputs may settle per vector
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle request to begin a sweep (accepted in IDLE/DONE)
//   A, B       out  operands driven to the adder (registered)
//   Cin        out  carry-in driven to the adder (registered)
//   S, Cout    in   sum and carry-out returned by the adder
//   busy       out  sweep in progress (SETTLE or CHECK)
//   done       out  sweep finished, held until the next accepted start
//   pass       out  done with zero mismatches
//   err_count  out  mismatching vectors in the current or last sweep
//   fail_vec   out  first failing {A,B,Cin}
//   fail_obs   out  {Cout,S} observed at the first failure
// ---------------------------------------------------------------------------
module adder_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic        Cin,
    input  logic [3:0]  S,
    input  logic        Cout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [9:0]  err_count,
    output logic [8:0]  fail_vec,
    output logic [4:0]  fail_obs
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [8:0] VEC_LAST   = 9'd511;

    // Reference 5-bit result {Cout,S} for a packed {A,B,Cin} vector.
    function automatic logic [4:0] expected_sum(input logic [8:0] vec);
        return {1'b0, vec[8:5]} + {1'b0, vec[4:1]} + {4'b0000, vec[0]};
    endfunction

    state_t      state_r, state_s;
    logic [8:0]  vec_r, vec_s;          // {A,B,Cin}; the index and the operands are the same bits
    logic [7:0]  cnt_r, cnt_s;
    logic [9:0]  err_r, err_s;
    logic        busy_r, done_r, pass_r;
    logic        mismatch_s;
    logic        start_ok_s;

    assign mismatch_s = (state_r == ST_CHECK) && ({Cout, S} != expected_sum(vec_r));

    // Next-state, vector index, settle counter and error count.
    always_comb begin
        state_s    = state_r;
        vec_s      = vec_r;
        cnt_s      = cnt_r;
        err_s      = err_r;
        start_ok_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_ok_s = 1'b1;
                    state_s    = ST_SETTLE;
                    vec_s      = 9'd0;
                    cnt_s      = CNT_RELOAD;
                    err_s      = 10'd0;
                end else begin
                    state_s    = state_r;
                end
            end
            ST_SETTLE: begin
                // CHECK is entered on the clock after the counter has reached 0,
                // giving SETTLE_CYCLES settle clocks plus one CHECK clock per vector.
                if (cnt_r == 8'd0) begin
                    state_s = ST_CHECK;
                end else begin
                    cnt_s   = cnt_r - 8'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    err_s = err_r + 10'd1;   // at most 512, fits in 10 bits
                end else begin
                    err_s = err_r;
                end
                if (vec_r == VEC_LAST) begin
                    state_s = ST_DONE;       // operands stay at 15/15/1
                end else begin
                    state_s = ST_SETTLE;
                    vec_s   = vec_r + 9'd1;
                    cnt_s   = CNT_RELOAD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, index, counter, error count and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            vec_r   <= 9'd0;
            cnt_r   <= 8'd0;
            err_r   <= 10'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            vec_r   <= vec_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
            busy_r  <= (state_s == ST_SETTLE) || (state_s == ST_CHECK);
            done_r  <= (state_s == ST_DONE);
            pass_r  <= (state_s == ST_DONE) && (err_s == 10'd0);
        end
    end

    assign A         = vec_r[8:5];
    assign B         = vec_r[4:1];
    assign Cin       = vec_r[0];
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_r;

`ifdef ADDER_SWEEP_FAILCAP_EN
    logic [8:0] fail_vec_r;
    logic [4:0] fail_obs_r;
    logic       capture_s;

    // Only the first mismatch of a sweep is captured (error count still zero).
    assign capture_s = mismatch_s && (err_r == 10'd0);

    // First-failure capture, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_vec_r <= 9'd0;
            fail_obs_r <= 5'd0;
        end else if (start_ok_s) begin
            fail_vec_r <= 9'd0;
            fail_obs_r <= 5'd0;
        end else if (capture_s) begin
            fail_vec_r <= vec_r;
            fail_obs_r <= {Cout, S};
        end else begin
            fail_vec_r <= fail_vec_r;
            fail_obs_r <= fail_obs_r;
        end
    end

    assign fail_vec = fail_vec_r;
    assign fail_obs = fail_obs_r;
`else
    assign fail_vec = 9'd0;
    assign fail_obs = 5'd0;
`endif

endmodule

// File: tb/tb_adder_sweep_checker.sv
// ---------------------------------------------------------------------------
// Testbench for adder_sweep_checker. A behavioural adder (optionally faulty)
// closes the loop. Expected sweep results are derived by walking all 512
// vectors against a golden sum, pushed to a scoreboard when a sweep is
// started, and popped and compared when done is observed.
// ---------------------------------------------------------------------------
module tb_adder_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start1;
    logic [3:0]  a_s, b_s, s_s;
    logic        cin_s, cout_s;
    logic        busy_s, done_s, pass_s;
    logic [9:0]  err_s;
    logic [8:0]  fvec_s;
    logic [4:0]  fobs_s;
    logic [3:0]  a1_s, b1_s, s1_s;
    logic        cin1_s, cout1_s;
    logic        busy1_s, done1_s, pass1_s;
    logic [9:0]  err1_s;
    logic [8:0]  fvec1_s;
    logic [4:0]  fobs1_s;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int fault_mode = 0;

    typedef struct {
        int err;
        int pass;
        int fvec;
        int fobs;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // fm: 0 correct, 1 Cout stuck at 0, 2 S[0] stuck at 0
    function automatic logic [4:0] adder_model(input logic [3:0] a, input logic [3:0] b,
                                               input logic c, input int fm);
        logic [4:0] r;
        r = 5'(a) + 5'(b) + 5'(c);
        if (fm == 1) r[4] = 1'b0;
        else if (fm == 2) r[0] = 1'b0;
        return r;
    endfunction

    assign {cout_s, s_s}   = adder_model(a_s, b_s, cin_s, fault_mode);
    assign {cout1_s, s1_s} = adder_model(a1_s, b1_s, cin1_s, 0);

    adder_sweep_checker #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A(a_s), .B(b_s), .Cin(cin_s), .S(s_s), .Cout(cout_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
        .fail_vec(fvec_s), .fail_obs(fobs_s)
    );

    adder_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .A(a1_s), .B(b1_s), .Cin(cin1_s), .S(s1_s), .Cout(cout1_s),
        .busy(busy1_s), .done(done1_s), .pass(pass1_s), .err_count(err1_s),
        .fail_vec(fvec1_s), .fail_obs(fobs1_s)
    );

    task automatic check_value(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input int fm);
        exp_t e;
        logic [8:0] v9;
        logic [4:0] obs;
        int golden;
        e.err = 0; e.fvec = 0; e.fobs = 0;
        for (int v = 0; v < 512; v++) begin
            v9 = 9'(v);
            golden = int'(v9[8:5]) + int'(v9[4:1]) + int'(v9[0]);
            obs = adder_model(v9[8:5], v9[4:1], v9[0], fm);
            if (int'(obs) != golden) begin
                if (e.err == 0) begin
                    e.fvec = v;
                    e.fobs = int'(obs);
                end
                e.err++;
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
`ifndef ADDER_SWEEP_FAILCAP_EN
        e.fvec = 0;
        e.fobs = 0;
`endif
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_sweep(input int fm, input bit track);
        exp_t e;
        int t0, last_change, changes, bad_gap, bad_order, prev;
        bit seen;
        fault_mode = fm;
        push_expected(fm);
        pulse_start();
        t0 = cyc;
        check_value("busy_after_start", int'(busy_s), 1);
        prev = int'({a_s, b_s, cin_s});
        check_value("first_vec", prev, 0);
        last_change = cyc; changes = 0; bad_gap = 0; bad_order = 0; seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (int'({a_s, b_s, cin_s}) != prev) begin
                changes++;
                if (cyc - last_change != 5) bad_gap++;
                if (int'({a_s, b_s, cin_s}) != prev + 1) bad_order++;
                prev = int'({a_s, b_s, cin_s});
                last_change = cyc;
            end
            if (done_s) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check_value("done_timeout", 0, 1);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        check_value("done_latency", cyc - t0, 2560);
        check_value("err_count", int'(err_s), e.err);
        check_value("pass", int'(pass_s), e.pass);
        check_value("busy_at_done", int'(busy_s), 0);
        check_value("fail_vec", int'(fvec_s), e.fvec);
        check_value("fail_obs", int'(fobs_s), e.fobs);
        check_value("final_vec", int'({a_s, b_s, cin_s}), 511);
        if (track) begin
            check_value("vec_changes", changes, 511);
            check_value("vec_gap_errors", bad_gap, 0);
            check_value("vec_order_errors", bad_order, 0);
        end
        // done must hold while idle in DONE
        repeat (3) @(negedge clk);
        check_value("done_hold", int'(done_s), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_busy"}, int'(busy_s), 0);
        check_value({tag, "_done"}, int'(done_s), 0);
        check_value({tag, "_pass"}, int'(pass_s), 0);
        check_value({tag, "_err"}, int'(err_s), 0);
        check_value({tag, "_fvec"}, int'(fvec_s), 0);
        check_value({tag, "_fobs"}, int'(fobs_s), 0);
        check_value({tag, "_vec"}, int'({a_s, b_s, cin_s}), 0);
    endtask

    initial begin
        int t0;
        bit seen;
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
        #23;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_value("idle_no_start", int'(busy_s), 0);

        run_sweep(0, 1'b1);    // correct adder
        run_sweep(1, 1'b0);    // Cout stuck at 0
        run_sweep(2, 1'b0);    // S[0] stuck at 0
        run_sweep(0, 1'b0);    // rerun clean after a faulty sweep

        // Reset mid-sweep with errors already accumulated
        fault_mode = 2;
        push_expected(2);
        pulse_start();
        repeat (1000) @(negedge clk);
        check_value("busy_before_reset", int'(busy_s), 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_value("idle_after_reset_busy", int'(busy_s), 0);
        check_value("idle_after_reset_done", int'(done_s), 0);
        run_sweep(0, 1'b0);

        // SETTLE_CYCLES=1 instance: second start while busy is ignored
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        t0 = cyc;
        repeat (3) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (done1_s) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            check_value("done1_timeout", 0, 1);
        end else begin
            check_value("done1_latency", cyc - t0, 1024);
            check_value("err1_count", int'(err1_s), 0);
            check_value("pass1", int'(pass1_s), 1);
            check_value("busy1_at_done", int'(busy1_s), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
